pic8259: RTL

- Single 8259A-style programmable interrupt controller at I/O ports 0x20/0x21.
- Consumes the interval timer's channel-0 output on IR0 (plus other chipset IRQ lines), latches edges, resolves fixed priority and raises one interrupt request to the CPU core.
- Supplies the 8-bit vector during the CPU's interrupt-acknowledge handshake.
- Uses the chipset's OR-combined read bus: oData is 0 when the block is not being read.

---
 rtl/pic8259.sv | 105 ++++++++++
 1 files changed

// File: rtl/pic8259.sv
// pic8259: 8259A-style interrupt controller at 0x20/0x21 with fixed priority and edge-latched IRQs.
// Optional auto-EOI support is enabled by defining PIC_AEOI_EN.
module pic8259 #(
  parameter logic [4:0] DEFAULT_BASE = 5'b00001
) (
  input  logic        iClk,
  input  logic        iRstN,
  input  logic [11:0] iAddr,
  input  logic [7:0]  iData,
  input  logic        iWr,
  input  logic        iRd,
  output logic [7:0]  oData,
  output logic        oSel,
  input  logic [7:0]  iIrq,
  output logic        oInt,
  input  logic        iInta,
  output logic [7:0]  oVector
);
  typedef enum logic [1:0] {READY, ICW2, ICW3, ICW4} state_t;
  state_t state, state_n;
  logic [7:0] irr, isr, imr, irq_prev, pending, edges, ack_bit, isr_eoi, irr_n, isr_n;
  logic [4:0] base;
  logic [2:0] lvl;
  logic rsel, sngl, ic4, aeoi, sel, wr, dwr, icw1, ocw2, ocw3, has_pend;

  assign sel      = iAddr[11:1] == 11'h010;
  assign wr       = iWr & sel;
  assign dwr      = wr & iAddr[0];
  assign icw1     = wr & ~iAddr[0] & iData[4];
  assign ocw2     = wr & ~iAddr[0] & ~iData[4] & ~iData[3];
  assign ocw3     = wr & ~iAddr[0] & ~iData[4] & iData[3];
  assign pending  = irr & ~imr;
  assign edges    = iIrq & ~irq_prev;
  assign has_pend = |pending;

  always_comb begin
    lvl = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (pending[i]) lvl = 3'(i);
  end

  assign ack_bit = (iInta & has_pend) ? 8'b1 << lvl : 8'h00;
  // isr & (isr-1) drops the lowest set bit: the non-specific EOI target
  assign isr_eoi = (ocw2 && iData[7:5] == 3'b001) ? isr & (isr - 8'd1) :
                   (ocw2 && iData[7:5] == 3'b011) ? isr & ~(8'b1 << iData[2:0]) : isr;
  assign irr_n   = icw1 ? edges : (irr & ~ack_bit) | edges;
  assign isr_n   = icw1 ? 8'h00 : isr_eoi | (aeoi ? 8'h00 : ack_bit);
  // Mask of levels strictly above the highest in-service one (all ones when ISR is empty)
  assign oInt    = |(pending & ((isr & (~isr + 8'd1)) - 8'd1));

  always_comb begin
    state_n = icw1 ? ICW2 :
              !dwr ? state :
              state == ICW2 ? (!sngl ? ICW3 : ic4 ? ICW4 : READY) :
              state == ICW3 ? (ic4 ? ICW4 : READY) : READY;
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) state <= READY;
    else        state <= state_n;
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      irr      <= 8'h00;
      isr      <= 8'h00;
      imr      <= 8'hFF;
      base     <= DEFAULT_BASE;
      rsel     <= 1'b0;
      sngl     <= 1'b0;
      ic4      <= 1'b0;
      irq_prev <= 8'h00;
      oData    <= 8'h00;
      oSel     <= 1'b0;
      oVector  <= 8'h00;
    end else begin
      irq_prev <= iIrq;
      irr      <= irr_n;
      isr      <= isr_n;
      if (icw1) begin
        imr  <= 8'h00;
        rsel <= 1'b0;
        sngl <= iData[1];
        ic4  <= iData[0];
      end else begin
        if (dwr && state == READY) imr <= iData;
        if (ocw3 && iData[1]) rsel <= iData[0];
      end
      if (dwr && state == ICW2) base <= iData[7:3];
      oSel  <= iRd & sel;
      oData <= (iRd & sel) ? (iAddr[0] ? imr : rsel ? isr : irr) : 8'h00;
      if (iInta) oVector <= {base, has_pend ? lvl : 3'd7};
    end
  end

`ifdef PIC_AEOI_EN
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN)                      aeoi <= 1'b0;
    else if (icw1)                   aeoi <= 1'b0;
    else if (dwr && state == ICW4)   aeoi <= iData[1];
  end
`else
  assign aeoi = 1'b0;
`endif
endmodule
